tile_scheduler: RTL

- Sequencing controller for the image tiler, which splits a SIZE x SIZE image into non-overlapping FILTER_SIZE x FILTER_SIZE tiles.
- On start, issues every tile index in raster order to the downstream convolution engine over a valid/ready handshake.
- Limits in-flight tiles with a credit counter and collects per-tile result acknowledgements.
- Signals done once all results have returned.

---
 rtl/tile_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tile_scheduler.sv
// Tile scheduler: issues SIZE/FILTER_SIZE squared tile descriptors in raster order under a credit limit.
// Optional stall-cycle counter enabled by defining TILE_SCHED_PERF_EN.
module tile_scheduler #(
    parameter  int SIZE            = 9,
    parameter  int FILTER_SIZE     = 3,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int OUT             = SIZE / FILTER_SIZE,
    localparam int NT              = OUT * OUT,
    localparam int IDX_W           = (NT > 1) ? $clog2(NT) : 1,
    localparam int RC_W            = (OUT > 1) ? $clog2(OUT) : 1,
    localparam int PX_W            = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CR_W            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic [IDX_W-1:0] tile_idx,
    output logic [RC_W-1:0]  tile_row,
    output logic [RC_W-1:0]  tile_col,
    output logic [PX_W-1:0]  pix_row0,
    output logic [PX_W-1:0]  pix_col0,
    output logic             tile_last,
    input  logic             res_valid,
    output logic [CR_W-1:0]  outstanding,
    output logic [IDX_W:0]   res_count,
    output logic             protocol_err,
    output logic [15:0]      stall_cycles,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [RC_W-1:0]   r_row;
    logic [RC_W-1:0]   r_col;
    logic [CR_W-1:0]   r_out;
    logic [IDX_W:0]    r_res;
    logic              r_err;
    logic [CR_W-1:0]   w_out_nxt;
    logic              w_valid;
    logic              w_hs;
    logic              w_acc;
    logic              w_spur;
    logic              w_start_acc;
    logic              w_last;

    // Handshake: a descriptor transfers on a rising edge where tile_valid && tile_ready.
    // tile_valid depends only on registers, so once raised it holds (with the fields)
    // until that edge; the credit count can only drop in the meantime.
    assign w_valid     = (r_state == S_ISSUE) && (r_out < CR_W'(MAX_OUTSTANDING));
    assign w_hs        = w_valid && tile_ready;
    assign w_acc       = res_valid && ((r_out != '0) || w_hs);
    assign w_spur      = res_valid && !w_acc;
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_last      = (r_idx == IDX_W'(NT - 1));

    always_comb begin
        w_out_nxt = r_out;
        if (w_hs && !w_acc) begin
            w_out_nxt = r_out + CR_W'(1);
        end else if (!w_hs && w_acc) begin
            w_out_nxt = r_out - CR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (w_hs && w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // The final result may arrive in the same cycle we decide to finish.
                if (w_out_nxt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
            r_out <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
            r_out <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (w_acc && (r_res != (IDX_W + 1)'(NT))) r_res <= r_res + (IDX_W + 1)'(1);
            if (w_spur) r_err <= 1'b1;
            // The last descriptor stays on the index registers after it is taken.
            if (w_hs && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
                if (r_col == RC_W'(OUT - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + RC_W'(1);
                end else begin
                    r_col <= r_col + RC_W'(1);
                end
            end
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_stall <= '0;
        end else if ((r_state == S_ISSUE) && !w_hs && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = 16'd0;
`endif

    assign tile_valid   = w_valid;
    assign tile_idx     = r_idx;
    assign tile_row     = r_row;
    assign tile_col     = r_col;
    assign pix_row0     = PX_W'(32'(r_row) * FILTER_SIZE);
    assign pix_col0     = PX_W'(32'(r_col) * FILTER_SIZE);
    assign tile_last    = w_valid && w_last;
    assign outstanding  = r_out;
    assign res_count    = r_res;
    assign protocol_err = r_err;
    assign dbg_state    = r_state;

endmodule
